// File: rtl/operand_collector.sv
// Operand collector: takes a micro-instruction header, gathers A/B/multi-beat C from the
// read stream, and holds one registered bundle for the execute stage until it is accepted.
module operand_collector #(
  parameter int DW       = 32,
  parameter int C_BEATS  = 2,
  parameter int UINSTR_W = 32,
  parameter int OPC_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  arst_i,
  input  logic                  flush_i,
  input  logic                  uinstr_valid_i,
  output logic                  uinstr_ready_o,
  input  logic [UINSTR_W-1:0]   uinstr_i,
  input  logic [1:0]            op_mode_i,
  input  logic                  rd_data_valid_i,
  output logic                  rd_data_ready_o,
  input  logic [DW-1:0]         rd_data_i,
  output logic [DW-1:0]         operand_a_o,
  output logic [DW-1:0]         operand_b_o,
  output logic [C_BEATS*DW-1:0] operand_c_o,
  output logic [OPC_W-1:0]      op_code_o,
  output logic [UINSTR_W-1:0]   uinstr_o,
  output logic                  op_valid_o,
  input  logic                  op_ready_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      op_count_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET_A = 3'd1;
  localparam logic [2:0] S_GET_B = 3'd2;
  localparam logic [2:0] S_GET_C = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int CBW = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam logic [CBW-1:0] C_LAST = CBW'(C_BEATS - 1);

  logic [2:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CBW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]         a_q, a_d, b_q, b_d;
  logic [C_BEATS*DW-1:0] c_q, c_d;
  logic [UINSTR_W-1:0]   uinstr_q, uinstr_d;
  logic                  uinstr_ready_q, uinstr_ready_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  op_valid_q, op_valid_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic hdr_hs, beat_hs, acc;

  // Handshakes are qualified by the registered ready/valid flags the outside world sees.
  assign hdr_hs  = uinstr_valid_i & uinstr_ready_q;
  assign beat_hs = rd_data_valid_i & rd_ready_q;
  assign acc     = op_valid_q & op_ready_i;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    uinstr_d = uinstr_q;
    count_d  = count_q;

    if (flush_i) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      c_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (hdr_hs) begin
          uinstr_d = uinstr_i;
          mode_d   = op_mode_i;
          a_d      = '0;
          b_d      = '0;
          c_d      = '0;
          cnt_d    = '0;
          state_d  = S_GET_A;
        end
        S_GET_A: if (beat_hs) begin
          a_d     = rd_data_i;
          state_d = (mode_q == 2'd0) ? S_HOLD : S_GET_B;
        end
        S_GET_B: if (beat_hs) begin
          b_d     = rd_data_i;
          state_d = (mode_q == 2'd1) ? S_HOLD : S_GET_C;
        end
        S_GET_C: if (beat_hs) begin
          // First C beat lands in the most significant slice.
          for (int k = 0; k < C_BEATS; k++)
            if (cnt_q == CBW'(k)) c_d[(C_BEATS-1-k)*DW +: DW] = rd_data_i;
          if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HOLD: if (acc) begin
          state_d = S_IDLE;
          count_d = count_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    uinstr_ready_d = (state_d == S_IDLE);
    rd_ready_d     = (state_d == S_GET_A) | (state_d == S_GET_B) | (state_d == S_GET_C);
    op_valid_d     = (state_d == S_HOLD);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      c_q            <= '0;
      uinstr_q       <= '0;
      uinstr_ready_q <= 1'b0;
      rd_ready_q     <= 1'b0;
      op_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      c_q            <= c_d;
      uinstr_q       <= uinstr_d;
      uinstr_ready_q <= uinstr_ready_d;
      rd_ready_q     <= rd_ready_d;
      op_valid_q     <= op_valid_d;
      busy_q         <= busy_d;
      count_q        <= count_d;
    end
  end

  assign uinstr_ready_o  = uinstr_ready_q;
  assign rd_data_ready_o = rd_ready_q;
  assign operand_a_o     = a_q;
  assign operand_b_o     = b_q;
  assign operand_c_o     = c_q;
  assign op_code_o       = uinstr_q[OPC_W-1:0];
  assign uinstr_o        = uinstr_q;
  assign op_valid_o      = op_valid_q;
  assign busy_o          = busy_q;
  assign op_count_o      = count_q;

endmodule
